ad7606_avg_filter: RTL
======================

// Module: ad7606_avg_filter
// PURPOSE
//  Downstream stage of the AD7606 controller: consumes its 8 parallel channel words and
//  one-cycle valid pulse, block-averages 2^AVG_LOG2 consecutive frames per channel, and
//  presents 8 averaged two's-complement results with a one-cycle valid pulse.
//  Uses one time-shared adder, one channel per cycle. Feeds the control/telemetry logic.
// PARAMETERS
//  DATA_W    16  sample width, equal to `AD_DATA_NBIT; samples are signed two's complement
//  AVG_LOG2  4   log2 of frames averaged (N = 2^AVG_LOG2); legal range 0..8
// PORTS
//  clk         in   1       system clock (50 MHz, same as the ADC controller)
//  rst_n       in   1       asynchronous, active-low reset
//  in_ch1..8   in   DATA_W  channel words from the ADC controller, stable when in_vd=1
//  in_vd       in   1       one-cycle frame-valid pulse
//  ovr_clr     in   1       clears the sticky overrun flag
//  out_ch1..8  out  DATA_W  averaged channel results, signed
//  out_vd      out  1       one-cycle pulse: out_ch1..8 updated this cycle
//  ovr         out  1       sticky: a frame arrived while busy and was dropped
//  busy        out  1       high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): out_ch1..8=0, out_vd=0, ovr=0, busy=0, accumulators=0,
//   frame_cnt=0, chan index k=0, state=IDLE. Reset mid-operation discards the partial average.
//  States: IDLE, SUM, DUMP.
//  IDLE: in_vd=1 at edge E0 -> latch in_ch1..8 into frame register, k<=0, go SUM.
//  SUM (edges E1..E8): acc[k] <= acc[k] + sign_ext(frame[k]); k++. At E8 (k=7):
//   if frame_cnt==N-1 -> DUMP, else frame_cnt++ and go IDLE.
//  DUMP (edge E9): out_chX <= acc[X] >>> AVG_LOG2 (arithmetic, truncation toward -inf),
//   low DATA_W bits; all 8 outputs update together; out_vd<=1 for exactly one cycle;
//   acc[*]<=0; frame_cnt<=0; go IDLE.
//  Latency: final frame's in_vd at E0 -> out_vd high in the cycle following E9.
//  Min frame spacing 10 cycles; AD7606 frame period far exceeds this.
//  Widths: acc is DATA_W+AVG_LOG2 signed, never overflows; the mean always fits DATA_W.
//  AVG_LOG2=0: every frame produces an output (pass-through, 10-cycle latency).
//  Overrun: in_vd=1 while state!=IDLE -> frame dropped, ovr<=1, acc/frame_cnt untouched.
//   ovr_clr=1 clears ovr; when set and clear coincide, set wins (ovr stays 1).
//  out_chX hold their value between out_vd pulses; out_vd=0 except in the DUMP cycle.
//  in_vd while in IDLE is always accepted, including the cycle right after DUMP.
// STRUCTURE
//  Shared header: `AD_DATA_NBIT, state encodings (IDLE/SUM/DUMP), N=1<<AVG_LOG2 constant.
//  Accumulators as an 8-entry register array indexed by k; single adder, single shifter.
//  No sub-module; the datapath is small enough to stay flat in this file.
// TESTING
//  1 AVG_LOG2=2, ch1 = 100,104,108,112 over 4 frames -> single out_vd after 4th frame
//    at E9+1, out_ch1=106; no out_vd after frames 1-3.
//  2 ch2 = -3,-2,-2,-2 (sum -9), AVG_LOG2=2 -> out_ch2 = -3 (16'hFFFD), floor rounding.
//  3 All channels 16'h7FFF x4 -> 16'h7FFF; all 16'h8000 x4 -> 16'h8000; no wrap.
//  4 Second in_vd 5 cycles after first -> dropped, ovr=1, result equals average without
//    it; ovr_clr pulse -> ovr=0; ovr_clr coincident with new overrun -> ovr=1.
//  5 rst_n low during SUM after 2 of 4 frames -> outputs/ovr/busy 0 immediately; next
//    4 frames of value 40 -> out=40 (no stale partial sum).
//  6 Frames exactly 10 cycles apart, 16 frames, AVG_LOG2=2 -> 4 out_vd pulses, ovr=0.

Source files
------------

// File: rtl/ad7606_avg_filter_pkg.sv
// Shared definitions for the AD7606 block-averaging filter.
package ad7606_avg_filter_pkg;

    // Width of one AD7606 conversion result.
    localparam int AD_DATA_NBIT = 16;

    // The converter always delivers eight channels per frame.
    localparam int NUM_CH = 8;

    // Controller states: waiting for a frame, summing one channel per cycle, emitting the mean.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUM  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    // Number of frames in one averaging block.
    function automatic int avg_frames(input int avg_log2);
        return 1 << avg_log2;
    endfunction

endpackage

// File: rtl/ad7606_avg_filter.sv
// Block-averages 2^AVG_LOG2 AD7606 frames per channel using one shared adder,
// visiting one channel per clock, and publishes all eight means together.
module ad7606_avg_filter
    import ad7606_avg_filter_pkg::*;
#(
    parameter int DATA_W   = AD_DATA_NBIT,
    parameter int AVG_LOG2 = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic signed [DATA_W-1:0] in_ch1,
    input  logic signed [DATA_W-1:0] in_ch2,
    input  logic signed [DATA_W-1:0] in_ch3,
    input  logic signed [DATA_W-1:0] in_ch4,
    input  logic signed [DATA_W-1:0] in_ch5,
    input  logic signed [DATA_W-1:0] in_ch6,
    input  logic signed [DATA_W-1:0] in_ch7,
    input  logic signed [DATA_W-1:0] in_ch8,
    input  logic                     in_vd,
    input  logic                     ovr_clr,
    output logic signed [DATA_W-1:0] out_ch1,
    output logic signed [DATA_W-1:0] out_ch2,
    output logic signed [DATA_W-1:0] out_ch3,
    output logic signed [DATA_W-1:0] out_ch4,
    output logic signed [DATA_W-1:0] out_ch5,
    output logic signed [DATA_W-1:0] out_ch6,
    output logic signed [DATA_W-1:0] out_ch7,
    output logic signed [DATA_W-1:0] out_ch8,
    output logic                     out_vd,
    output logic                     ovr,
    output logic                     busy
);

    localparam int N     = avg_frames(AVG_LOG2);
    // N samples of DATA_W bits sum into DATA_W+AVG_LOG2 bits without overflow.
    localparam int ACC_W = DATA_W + AVG_LOG2;
    // One spare bit keeps the counter non-empty when AVG_LOG2 is 0.
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    state_t                   state, next_state;
    logic [2:0]               k;
    logic [CNT_W-1:0]         frame_cnt;
    logic signed [DATA_W-1:0] in_arr   [NUM_CH];
    logic signed [DATA_W-1:0] frame_p0 [NUM_CH];
    logic signed [ACC_W-1:0]  acc      [NUM_CH];
    logic signed [DATA_W-1:0] avg_q    [NUM_CH];
    logic                     last_chan;
    logic                     last_frame;

    function automatic logic signed [ACC_W-1:0] sign_ext(input logic signed [DATA_W-1:0] x);
        return ACC_W'(x);
    endfunction

    // Arithmetic shift gives the floor of the mean; it always fits back into DATA_W.
    function automatic logic signed [DATA_W-1:0] avg_scale(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> AVG_LOG2;
        return sh[DATA_W-1:0];
    endfunction

    assign in_arr[0] = in_ch1;
    assign in_arr[1] = in_ch2;
    assign in_arr[2] = in_ch3;
    assign in_arr[3] = in_ch4;
    assign in_arr[4] = in_ch5;
    assign in_arr[5] = in_ch6;
    assign in_arr[6] = in_ch7;
    assign in_arr[7] = in_ch8;

    assign out_ch1 = avg_q[0];
    assign out_ch2 = avg_q[1];
    assign out_ch3 = avg_q[2];
    assign out_ch4 = avg_q[3];
    assign out_ch5 = avg_q[4];
    assign out_ch6 = avg_q[5];
    assign out_ch7 = avg_q[6];
    assign out_ch8 = avg_q[7];

    assign last_chan  = (k == 3'd7);
    assign last_frame = (frame_cnt == CNT_LAST);
    assign busy       = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // Next-state selection: a frame starts a sum pass; the last pass of a block dumps.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (in_vd) next_state = ST_SUM;
            ST_SUM:  if (last_chan) next_state = last_frame ? ST_DUMP : ST_IDLE;
            ST_DUMP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Frame capture stage: hold the accepted words while the adder walks the channels.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && in_vd) begin
            for (int i = 0; i < NUM_CH; i++) frame_p0[i] <= in_arr[i];
        end
    end

    // Accumulate/dump stage: one channel added per cycle, all means published at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k         <= 3'd0;
            frame_cnt <= '0;
            out_vd    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i]   <= '0;
                avg_q[i] <= '0;
            end
        end else begin
            out_vd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_vd) k <= 3'd0;
                end
                ST_SUM: begin
                    acc[k] <= acc[k] + sign_ext(frame_p0[k]);
                    k      <= k + 3'd1;
                    if (last_chan && !last_frame) frame_cnt <= frame_cnt + CNT_W'(1);
                end
                ST_DUMP: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        avg_q[i] <= avg_scale(acc[i]);
                        acc[i]   <= '0;
                    end
                    frame_cnt <= '0;
                    out_vd    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun flag: a frame arriving while busy is dropped; a new set beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 ovr <= 1'b0;
        else if (in_vd && busy)     ovr <= 1'b1;
        else if (ovr_clr)           ovr <= 1'b0;
    end

endmodule
